// File: rtl/minisys_pkg.sv
// Shared Minisys fetch definitions: default widths, reset PC, NOP encoding and FIFO entry layout.
package minisys_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pcplus4;
    } fetch_entry_t;

    // Saturating 32-bit event counter step.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/minisys_sync_fifo.sv
// Synchronous FIFO with push/pop/clear; head word is presented combinationally on rdata.
module minisys_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] ptr);
        return (32'(ptr) == DEPTH - 1) ? '0 : ptr + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/minisys_fetch_queue.sv
// Decoupled IF stage: credit-limited imem requests, prefetch FIFO, D register with stall/redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush/empty performance counters.
module minisys_fetch_queue
    import minisys_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            pc_srcM,
    input  logic [XLEN-1:0] pc_branchM,
    input  logic            load_use,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcplus4D,
    output logic            validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush,
    output logic [31:0]     perf_empty
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT) + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [OW-1:0]   drop;
    logic [OW-1:0]   outstanding;
    logic [XLEN-1:0] tag_pc;
    logic            tag_full;
    logic            tag_empty;
    entry_t          pf_wdata;
    entry_t          pf_head;
    logic            pf_full;
    logic            pf_empty;
    logic [CW-1:0]   pf_count;
    logic            issue;
    logic            fire;
    logic            deliver;
    logic            d_pop;

    // Credits cover both buffered words and words still in flight, so a push never meets a full FIFO.
    assign issue = (32'(pf_count) + 32'(outstanding) < DEPTH) && !tag_full && !pf_full && !pc_srcM;

    assign imem_req  = issue && clrn;
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;
    assign deliver   = imem_rvalid && !tag_empty && (drop == '0) && !pc_srcM;
    assign d_pop     = !pc_srcM && !load_use && !pf_empty;
    assign pf_wdata  = '{instr: imem_rdata, pcplus4: tag_pc + XLEN'(4)};

    // Tag queue: request PCs in issue order; its occupancy is the in-flight count.
    minisys_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_tag_q (
        .clk   (clk),
        .clrn  (clrn),
        .push  (fire),
        .pop   (imem_rvalid),
        .clear (1'b0),
        .wdata (pc),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (outstanding)
    );

    minisys_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_prefetch_q (
        .clk   (clk),
        .clrn  (clrn),
        .push  (deliver),
        .pop   (d_pop),
        .clear (pc_srcM),
        .wdata (pf_wdata),
        .rdata (pf_head),
        .full  (pf_full),
        .empty (pf_empty),
        .count (pf_count)
    );

    // PC and stale-response accounting; every request still in flight at a redirect is stale.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else if (pc_srcM) begin
            pc   <= pc_branchM & ~XLEN'(3);
            drop <= outstanding - OW'(imem_rvalid);
        end else begin
            if (fire) pc <= pc + XLEN'(4);
            if (imem_rvalid && (drop != '0)) drop <= drop - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            instrD   <= '0;
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (pc_srcM || (!load_use && pf_empty)) begin
            instrD   <= XLEN'(NOP_INSTR);
            pcplus4D <= '0;
            validD   <= 1'b0;
        end else if (!load_use) begin
            instrD   <= pf_head.instr;
            pcplus4D <= pf_head.pcplus4;
            validD   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
            perf_empty   <= '0;
        end else begin
            perf_fetched <= sat_inc32(perf_fetched, deliver);
            perf_stall   <= sat_inc32(perf_stall, load_use);
            perf_flush   <= sat_inc32(perf_flush, pc_srcM);
            perf_empty   <= sat_inc32(perf_empty, !pc_srcM && !load_use && pf_empty);
        end
    end
`endif

endmodule

// File: tb/tb_minisys_fetch_queue.sv
// Randomized bench for minisys_fetch_queue with an in-order imem responder and a queue-based reference model.
module tb_minisys_fetch_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        pc_srcM = 1'b0;
    logic [31:0] pc_branchM = '0;
    logic        load_use = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush, perf_empty;
`endif

    minisys_fetch_queue #(
        .XLEN    (32),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .pc_srcM    (pc_srcM),
        .pc_branchM (pc_branchM),
        .load_use   (load_use),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush),
        .perf_empty  (perf_empty)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } ent_t;

    req_t        inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] m_pc, m_di, m_dp, seq_pc;
    bit          m_dv;
    int          cyc;
    int          lat_lo = 1, lat_hi = 1;
    int          n_grant;
    bit          last_req;
    logic [31:0] last_addr;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; load_use = 1'b0;
        pc_srcM = 1'b0; pc_branchM = '0; imem_rdata = '0;
        #1;
        chk("rst_validD", 32'(validD), 32'd0);
        chk("rst_instrD", instrD, 32'd0);
        chk("rst_pcplus4D", pcplus4D, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        inflight.delete(); fifo_m.delete();
        m_pc = 0; m_dv = 0; m_di = 0; m_dp = 0; seq_pc = 0;
        @(posedge clk); @(posedge clk); #1;
        clrn = 1'b1; cyc = 0;
    endtask

    // One clock cycle: drive inputs, check issue, advance the model, check D after the edge.
    task automatic step(input bit gnt, input bit lu, input bit redir, input logic [31:0] tgt, input bit rv_en);
        bit   rv, exp_req, fire, d_new;
        req_t r;
        ent_t e;
        rv = rv_en && (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_gnt = gnt; load_use = lu; pc_srcM = redir; pc_branchM = tgt; imem_rvalid = rv;
        imem_rdata = rv ? instr_of(inflight[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_req = (fifo_m.size() + inflight.size() < DEPTH) && (inflight.size() < MAX_OUT) && !redir;
        last_req = imem_req; last_addr = imem_addr;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        if (imem_req && gnt) n_grant++;
        fire  = exp_req && gnt;
        d_new = 1'b0;
        if (redir) begin
            m_dv = 0; m_di = 0; m_dp = 0;
        end else if (!lu) begin
            if (fifo_m.size() > 0) begin
                e = fifo_m.pop_front();
                m_dv = 1; m_di = e.instr; m_dp = e.pcp4; d_new = 1'b1;
            end else begin
                m_dv = 0; m_di = 0; m_dp = 0;
            end
        end
        if (rv) begin
            r = inflight.pop_front();
            if (!r.stale && !redir) begin
                e.instr = instr_of(r.addr);
                e.pcp4  = r.addr + 32'd4;
                fifo_m.push_back(e);
            end
        end
        if (redir) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_pc = tgt & 32'hFFFF_FFFC;
            seq_pc = m_pc;
        end
        if (fire) begin
            r.addr = m_pc; r.due = cyc + int'($urandom_range(lat_hi, lat_lo)); r.stale = 1'b0;
            inflight.push_back(r);
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk); #1;
        cyc++;
        chk("validD", 32'(validD), 32'(m_dv));
        chk("instrD", instrD, m_di);
        if (m_dv) chk("pcplus4D", pcplus4D, m_dp);
        if (d_new) begin
            chk("seq_instr", instrD, instr_of(seq_pc));
            chk("seq_pcplus4", pcplus4D, seq_pc + 32'd4);
            seq_pc = seq_pc + 32'd4;
        end
    endtask

    task automatic wait_valid(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, 0, 1);
            found = validD;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    initial begin
        bit          found;
        bit          redir;
        logic [31:0] tgt;
        #2;

        // Sequential fetch from reset, 1-cycle memory.
        do_reset(); lat_lo = 1; lat_hi = 1;
        step(1, 0, 0, 0, 1);
        chk("t1_addr0", last_addr, 32'h0);
        chk("t1_valid_c1", 32'(validD), 32'd0);
        step(1, 0, 0, 0, 1);
        chk("t1_addr1", last_addr, 32'h4);
        chk("t1_valid_c2", 32'(validD), 32'd0);
        step(1, 0, 0, 0, 1);
        chk("t1_addr2", last_addr, 32'h8);
        chk("t1_valid_c3", 32'(validD), 32'd1);
        chk("t1_instr", instrD, instr_of(32'h0));
        chk("t1_pcplus4", pcplus4D, 32'h4);

        // Responses withheld: only MAX_OUT grants.
        do_reset(); n_grant = 0;
        repeat (6) step(1, 0, 0, 0, 0);
        chk("t2_grants", 32'(n_grant), 32'd2);
        chk("t2_req_idle", 32'(last_req), 32'd0);
        repeat (6) step(1, 0, 0, 0, 1);

        // Stall with full FIFO, then release.
        do_reset();
        repeat (3) step(1, 0, 0, 0, 1);
        chk("t3_first", instrD, instr_of(32'h0));
        repeat (8) step(1, 1, 0, 0, 1);
        chk("t3_hold_instr", instrD, instr_of(32'h0));
        chk("t3_hold_req", 32'(last_req), 32'd0);
        step(1, 0, 0, 0, 1);
        chk("t3_next_instr", instrD, instr_of(32'h4));
        chk("t3_next_pcp4", pcplus4D, 32'h8);
        step(1, 0, 0, 0, 1);
        chk("t3_next2_pcp4", pcplus4D, 32'hC);

        // Redirect with two requests in flight.
        do_reset();
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h100, 0);
        chk("t4_bubble", 32'(validD), 32'd0);
        wait_valid("t4_found", found);
        chk("t4_instr", instrD, instr_of(32'h100));
        chk("t4_pcp4", pcplus4D, 32'h104);

        // Redirect coincident with load_use and a response.
        do_reset();
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h200, 1);
        chk("t5_valid", 32'(validD), 32'd0);
        chk("t5_instr", instrD, 32'd0);
        step(1, 0, 0, 0, 1);
        chk("t5_req", 32'(last_req), 32'd1);
        chk("t5_addr", last_addr, 32'h200);
        wait_valid("t5_found", found);
        chk("t5_first_instr", instrD, instr_of(32'h200));
        chk("t5_first_pcp4", pcplus4D, 32'h204);

        // PC wrap at the top of the address space.
        do_reset();
        step(1, 0, 1, 32'hFFFF_FFF8, 0);
        repeat (3) step(1, 0, 0, 0, 1);
        chk("t6_wrap_addr", last_addr, 32'h0);

        // Random traffic with a mid-run asynchronous reset.
        do_reset(); lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 6000; i++) begin
            if (i == 3000) do_reset();
            redir = ($urandom_range(99) < 3);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                           : ($urandom & 32'h0000_FFFF);
            step($urandom_range(9) < 7, $urandom_range(9) < 2, redir, tgt, $urandom_range(9) < 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
